mash_ecn: RTL and testbench
===========================

# mash_ecn

Error-cancellation network for the pipelined MASH 1-1-1 delta-sigma modulator. It consumes the three per-stage carry bits of the accumulator chain and removes the pipeline skew between them. It combines the carries through first- and second-order differentiators into a signed noise-shaped sequence and adds that sequence to the integer divide ratio. It sits between the accumulator chain and the fractional-N divider control.

## Interface
Parameters:
- P_STAGE_LAT, 1 — pipeline latency in cycles between successive accumulator stages; range 1..4.
- P_DIV_WIDTH, 8 — width of the integer ratio and the divider output.

Ports:
- i_clk  in  1  — clock; single clock domain.
- i_rst  in  1  — reset; synchronous, active-high.
- i_en  in  1  — sample enable, one modulator sample per high cycle.
- i_c1  in  1  — stage-1 carry, earliest in time.
- i_c2  in  1  — stage-2 carry; lags c1 by P_STAGE_LAT samples.
- i_c3  in  1  — stage-3 carry; lags c1 by 2·P_STAGE_LAT samples.
- i_nint  in  P_DIV_WIDTH  — integer divide ratio, unsigned.
- o_y  out  4  — noise-shaped correction, two's complement, range −3..+4.
- o_div  out  P_DIV_WIDTH  — i_nint + o_y, unsigned.
- o_valid  out  1  — history filled; o_y and o_div are meaningful.

## Operation
- Alignment:
  - a1 = c1 delayed 2·P_STAGE_LAT enabled samples.
  - a2 = c2 delayed P_STAGE_LAT enabled samples.
  - a3 = c3, undelayed.
- History: a2p = previous a2; a3p1 and a3p2 = a3 one and two samples back.
- y = a1 + (a2 − a2p) + (a3 − 2·a3p1 + a3p2).
  - Computed in at least 4-bit signed arithmetic.
  - No saturation is needed; the range −3..+4 is exact.
- div = i_nint + sign-extended y, truncated modulo 2^P_DIV_WIDTH.
  - The caller keeps i_nint in 3..2^P_DIV_WIDTH−5; outside that range the result wraps and is not flagged.
- Fill counter:
  - Counts enabled samples and saturates at F = 2·P_STAGE_LAT + 2.
  - o_valid is registered; it goes to 1 on the enabled edge at which the counter already equals F−1 (the F-th sample).
- i_en low: every register holds, including the delay lines, fill counter and outputs.
- Reset: o_y = 0, o_div = 0, o_valid = 0, all delay and history bits 0, fill counter 0.
  - Reset has priority over i_en.
  - Reset mid-stream discards all history; the next F samples run warm-up again.

## Timing
- Latency is 1 cycle: inputs sampled at enabled edge n appear on o_y, o_div and o_valid after edge n.
- Delay lines and history advance only on enabled edges; the pipeline has no bubbles and no backpressure.
- i_nint is sampled on the same edge as the carries; a change takes effect on the next output.
- During warm-up (o_valid = 0), o_y and o_div are computed from zero history and are not forced.

## Configuration
- MASH_ECN_ORDER3_EN defined:
  - Full MASH 1-1-1 as above.
  - i_c3 is used; output range −3..+4; F = 2·P_STAGE_LAT + 2.
- MASH_ECN_ORDER3_EN undefined:
  - MASH 1-1 only; i_c3 is ignored.
  - a1 = c1 delayed P_STAGE_LAT; y = a1 + a2 − a2p with a2 = i_c2 undelayed.
  - Range −1..+2; F = P_STAGE_LAT + 1.
  - The a3 history registers are not instantiated.
  - Port list is unchanged; o_y stays 4 bits.

## Structure
- Shared package mash_pkg:
  - the o_y width constant (4), with typedef y_t for the signed correction value;
  - the fill-count width function of P_STAGE_LAT;
  - the range constants Y_MIN = −3 and Y_MAX = 4.
- One sub-module, mash_bit_delay: a parameterised enabled shift register with depth, synchronous reset and enable.
  - It is used for the c1 and c2 alignment lines and the a3 history.
- The top level holds the sum, the div adder, the fill counter and the output registers.

## Test plan
P_STAGE_LAT = 1, MASH_ECN_ORDER3_EN defined, i_nint = 20, i_en = 1 unless stated.
- All carries 0 for 10 samples → o_y = 0, o_div = 20; o_valid rises on the 4th output.
- Single i_c3 pulse at sample k → o_y = +1, −2, +1 on outputs k, k+1, k+2; o_div = 21, 18, 21.
- Single i_c2 pulse at sample k → o_y = +1 at output k+1 and −1 at output k+2.
- Single i_c1 pulse at sample k → o_y = +1 at output k+2 only.
- Extremes:
  - Pattern giving a1 = a2 = a3 = a3p2 = 1 with a2p = a3p1 = 0 → o_y = +4 (4'b0100), o_div = 24.
  - Pattern giving a2p = a3p1 = 1 with all others 0 → o_y = −3 (4'b1101), o_div = 17.
- Enable and reset:
  - Drop i_en for 3 cycles in the middle of a c3 pulse response → outputs frozen, then the sequence resumes with no lost sample.
  - Assert i_rst for 1 cycle mid-stream → next output 0/0/0 and o_valid low for 4 samples.

Source files
------------

// File: rtl/mash_pkg.sv
// ============================================================================
// Module      : mash_pkg
// Description : Shared types and constants for the MASH error-cancellation
//               network (correction width, range, fill-counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mash_pkg;

    localparam int Y_W   = 4;
    localparam int Y_MIN = -3;
    localparam int Y_MAX = 4;

    typedef logic signed [Y_W-1:0] y_t;

    // Wide enough for the largest warm-up length, 2*lat+2.
    function automatic int fill_cnt_width(input int lat);
        return $clog2(2 * lat + 3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mash_bit_delay.sv
// ============================================================================
// Module      : mash_bit_delay
// Description : Single-bit shift register of DEPTH stages that advances only
//               on enabled cycles; synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mash_bit_delay #(
    parameter int DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge i_clk) begin
                if (i_rst)     r_sr <= '0;
                else if (i_en) r_sr <= i_d;
            end
        end else begin : g_chain
            always_ff @(posedge i_clk) begin
                if (i_rst)     r_sr <= '0;
                else if (i_en) r_sr <= {r_sr[DEPTH-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mash_ecn.sv
// ============================================================================
// Module      : mash_ecn
// Description : MASH error-cancellation network: aligns the stage carries,
//               differentiates them and adds the correction to the ratio.
//               Define MASH_ECN_ORDER3_EN for the full 1-1-1 form; otherwise
//               a 1-1 network is built and i_c3 is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mash_ecn
    import mash_pkg::*;
#(
    parameter int P_STAGE_LAT = 1,
    parameter int P_DIV_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_c1,
    input  logic                   i_c2,
    input  logic                   i_c3,
    input  logic [P_DIV_WIDTH-1:0] i_nint,
    output logic [Y_W-1:0]         o_y,
    output logic [P_DIV_WIDTH-1:0] o_div,
    output logic                   o_valid
);

    localparam int C_CNT_W = fill_cnt_width(P_STAGE_LAT);

    logic w_a1, w_a2, w_a2p, w_a3, w_a3p1, w_a3p2;

`ifdef MASH_ECN_ORDER3_EN
    localparam int C_FILL = 2 * P_STAGE_LAT + 2;

    mash_bit_delay #(.DEPTH(2 * P_STAGE_LAT)) u_c1_line (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(i_c1), .o_q(w_a1));
    mash_bit_delay #(.DEPTH(P_STAGE_LAT)) u_c2_line (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(i_c2), .o_q(w_a2));
    mash_bit_delay #(.DEPTH(1)) u_a2_hist (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(w_a2), .o_q(w_a2p));
    mash_bit_delay #(.DEPTH(1)) u_a3_hist1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(w_a3), .o_q(w_a3p1));
    mash_bit_delay #(.DEPTH(1)) u_a3_hist2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(w_a3p1), .o_q(w_a3p2));

    assign w_a3 = i_c3;
`else
    localparam int C_FILL = P_STAGE_LAT + 1;

    // Second-order terms vanish; the third carry has no consumer here.
    logic w_unused_c3;
    assign w_unused_c3 = i_c3;

    mash_bit_delay #(.DEPTH(P_STAGE_LAT)) u_c1_line (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(i_c1), .o_q(w_a1));
    mash_bit_delay #(.DEPTH(1)) u_a2_hist (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(w_a2), .o_q(w_a2p));

    assign w_a2   = i_c2;
    assign w_a3   = 1'b0;
    assign w_a3p1 = 1'b0;
    assign w_a3p2 = 1'b0;
`endif

    y_t                     w_y;
    logic [P_DIV_WIDTH-1:0] w_div;

    assign w_y = y_t'({3'b000, w_a1})
               + y_t'({3'b000, w_a2}) - y_t'({3'b000, w_a2p})
               + y_t'({3'b000, w_a3}) - y_t'({2'b00, w_a3p1, 1'b0})
               + y_t'({3'b000, w_a3p2});

    assign w_div = i_nint + P_DIV_WIDTH'(w_y);

    logic [C_CNT_W-1:0]     r_cnt;
    logic [Y_W-1:0]         r_y;
    logic [P_DIV_WIDTH-1:0] r_div;
    logic                   r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_y     <= '0;
            r_div   <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            if (r_cnt != C_CNT_W'(C_FILL))
                r_cnt <= r_cnt + 1'b1;
            r_y     <= w_y;
            r_div   <= w_div;
            r_valid <= (r_cnt >= C_CNT_W'(C_FILL - 1));
        end
    end

    assign o_y     = r_y;
    assign o_div   = r_div;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mash_ecn.sv
// ============================================================================
// Module      : tb_mash_ecn
// Description : Directed bench for mash_ecn with a history-based reference
//               model; works with or without MASH_ECN_ORDER3_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mash_ecn;

    localparam int L = 1;
`ifdef MASH_ECN_ORDER3_EN
    localparam bit ORD3 = 1'b1;
    localparam int F    = 2 * L + 2;
`else
    localparam bit ORD3 = 1'b0;
    localparam int F    = L + 1;
`endif

    logic       clk, rst, en, c1, c2, c3;
    logic [7:0] nint;
    logic [3:0] y;
    logic [7:0] div;
    logic       valid;

    int npass  = 0;
    int ntotal = 0;

    mash_ecn #(.P_STAGE_LAT(L), .P_DIV_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_c1(c1), .i_c2(c2), .i_c3(c3),
        .i_nint(nint), .o_y(y), .o_div(div), .o_valid(valid));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: y as a sum over the raw carry history, newest first.
    int  q1[$], q2[$], q3[$];
    int  cnt = 0, ey = 0, ediv = 0, ev = 0;
    bit  started = 1'b0;

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q1.delete(); q2.delete(); q3.delete();
            cnt = 0; ey = 0; ediv = 0; ev = 0;
            started = 1'b1;
        end else if (en) begin
            q1.push_front(int'(c1));
            q2.push_front(int'(c2));
            q3.push_front(int'(c3));
            cnt++;
            if (ORD3)
                ey = at(q1, 2*L) + at(q2, L) - at(q2, L+1)
                   + at(q3, 0) - 2*at(q3, 1) + at(q3, 2);
            else
                ey = at(q1, L) + at(q2, 0) - at(q2, 1);
            ediv = (int'(nint) + ey) & 255;
            ev   = (cnt >= F) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_y",     int'($signed(y)), ey);
            chk("model_div",   int'(div),        ediv);
            chk("model_valid", int'(valid),      ev);
        end
    end

    task automatic step(input bit e, input bit a, input bit b, input bit c);
        en = e; c1 = a; c2 = b; c3 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int ey_l, input int ediv_l);
        chk({nm, "_y"},   int'($signed(y)), ey_l);
        chk({nm, "_div"}, int'(div),        ediv_l);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; c1 = 0; c2 = 0; c3 = 0; nint = 8'd20;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        lit("reset", 0, 0);
        chk("reset_valid", int'(valid), 0);
        rst = 1'b0;

        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0, 0);
            lit("zeros", 0, 20);
            chk("warmup_valid", int'(valid), (i >= F) ? 1 : 0);
        end

        step(1, 0, 0, 1); lit("c3_k0", ORD3 ?  1 : 0, ORD3 ? 21 : 20);
        step(1, 0, 0, 0); lit("c3_k1", ORD3 ? -2 : 0, ORD3 ? 18 : 20);
        step(1, 0, 0, 0); lit("c3_k2", ORD3 ?  1 : 0, ORD3 ? 21 : 20);
        step(1, 0, 0, 0);

        step(1, 0, 1, 0); lit("c2_k0", ORD3 ?  0 :  1, ORD3 ? 20 : 21);
        step(1, 0, 0, 0); lit("c2_k1", ORD3 ?  1 : -1, ORD3 ? 21 : 19);
        step(1, 0, 0, 0); lit("c2_k2", ORD3 ? -1 :  0, ORD3 ? 19 : 20);
        step(1, 0, 0, 0);

        step(1, 1, 0, 0); lit("c1_k0", 0, 20);
        step(1, 0, 0, 0); lit("c1_k1", ORD3 ? 0 : 1, ORD3 ? 20 : 21);
        step(1, 0, 0, 0); lit("c1_k2", ORD3 ? 1 : 0, ORD3 ? 21 : 20);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // a1 = a2 = a3 = a3p2 = 1, a2p = a3p1 = 0
        step(1, 1, 0, 1);
        step(1, 0, 1, 0);
        step(1, 0, 0, 1); lit("max", ORD3 ? 4 : -1, ORD3 ? 24 : 19);
        if (ORD3) chk("max_bits", int'(y), 4);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        // a2p = a3p1 = 1, all others 0
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0); lit("min", ORD3 ? -3 : 0, ORD3 ? 17 : 20);
        if (ORD3) chk("min_bits", int'(y), 13);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        // Enable low freezes everything; carries driven high must be ignored.
        step(1, 0, 0, 1); lit("en_k0", ORD3 ? 1 : 0, ORD3 ? 21 : 20);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1);
            lit("en_hold", ORD3 ? 1 : 0, ORD3 ? 21 : 20);
        end
        step(1, 0, 0, 0); lit("en_k1", ORD3 ? -2 : 0, ORD3 ? 18 : 20);
        step(1, 0, 0, 0); lit("en_k2", ORD3 ?  1 : 0, ORD3 ? 21 : 20);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        nint = 8'd100;
        step(1, 0, 0, 0); lit("nint", 0, 100);
        nint = 8'd20;
        step(1, 0, 0, 0); lit("nint_back", 0, 20);

        // Mid-stream reset discards history and restarts warm-up.
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        rst = 1'b1;
        step(1, 1, 1, 1); lit("rst_mid", 0, 0);
        chk("rst_mid_valid", int'(valid), 0);
        rst = 1'b0;
        for (int i = 1; i <= F + 1; i++) begin
            step(1, 0, 0, 0);
            lit("rewarm", 0, 20);
            chk("rewarm_valid", int'(valid), (i >= F) ? 1 : 0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

`default_nettype wire
